// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline stage state encodings, counter width and payload widths
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } state_t;

  localparam int DEFAULT_CNT_W = 16;

  localparam int WIDTH_IF_ID  = 65;
  localparam int WIDTH_ID_EX  = 148;
  localparam int WIDTH_EX_MEM = 140;
  localparam int WIDTH_MEM_WB = 137;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with async active-low clear
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count <= '0;
    end else if (en && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic pipeline register with optional skid slot, flush and stall counter
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SKID  = 1,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t           state;
  state_t           state_next;
  logic             main_valid;
  logic             skid_valid;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic             up_fire;
  logic             dn_fire;
  logic             load_main_up;
  logic             load_main_skid;

  assign main_valid = (state != EMPTY);
  assign skid_valid = (state == FULL);
  assign up_fire    = up_valid && up_ready;
  assign dn_fire    = main_valid && dn_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    load_main_up   = 1'b0;
    load_main_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (up_fire) begin
          state_next   = BUSY;
          load_main_up = 1'b1;
        end
      end
      BUSY: begin
        if (up_fire && dn_fire) begin
          load_main_up = 1'b1;
        end else if (up_fire && (SKID != 0)) begin
          state_next = FULL;
        end else if (dn_fire) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (dn_fire) begin
          state_next     = BUSY;
          load_main_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
    // Flush wins over every transition; the upstream word of this cycle is dropped.
    if (flush) begin
      state_next     = EMPTY;
      load_main_up   = 1'b0;
      load_main_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_data <= '0;
    end else if (load_main_up) begin
      main_data <= up_data;
    end else if (load_main_skid) begin
      main_data <= skid_data;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [WIDTH-1:0] skid_q;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          skid_q <= '0;
        end else if ((state == BUSY) && (state_next == FULL)) begin
          skid_q <= up_data;
        end
      end
      assign skid_data = skid_q;
      // Registered ready: only the FULL state refuses new words.
      assign up_ready  = (state != FULL);
    end else begin : g_noskid
      assign skid_data = '0;
      assign up_ready  = !main_valid || dn_ready;
    end
  endgenerate

  assign dn_valid  = main_valid;
  assign dn_data   = main_data;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .clr_n(reset),
    .en   (dn_valid && !dn_ready),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - self-checking bench for pipe_stage_elastic in skid, no-skid and short-counter builds
module tb_pipe_stage_elastic;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // SKID=1, WIDTH=32, CNT_W=16
  logic        s_fl = 0, s_uv = 0, s_ur, s_dv, s_dr = 0;
  logic [31:0] s_ud = 0, s_dd;
  logic [1:0]  s_occ;
  logic [15:0] s_st;
  // SKID=0
  logic        n_fl = 0, n_uv = 0, n_ur, n_dv, n_dr = 0;
  logic [31:0] n_ud = 0, n_dd;
  logic [1:0]  n_occ;
  logic [15:0] n_st;
  // SKID=1, CNT_W=4
  logic        t_fl = 0, t_uv = 0, t_ur, t_dv, t_dr = 0;
  logic [31:0] t_ud = 0, t_dd;
  logic [1:0]  t_occ;
  logic [3:0]  t_st;

  pipe_stage_elastic #(.WIDTH(32), .SKID(1), .CNT_W(16)) u_skid (
    .clk(clk), .reset(reset), .flush(s_fl), .up_valid(s_uv), .up_ready(s_ur),
    .up_data(s_ud), .dn_valid(s_dv), .dn_ready(s_dr), .dn_data(s_dd),
    .occupancy(s_occ), .stall_cnt(s_st));

  pipe_stage_elastic #(.WIDTH(32), .SKID(0), .CNT_W(16)) u_noskid (
    .clk(clk), .reset(reset), .flush(n_fl), .up_valid(n_uv), .up_ready(n_ur),
    .up_data(n_ud), .dn_valid(n_dv), .dn_ready(n_dr), .dn_data(n_dd),
    .occupancy(n_occ), .stall_cnt(n_st));

  pipe_stage_elastic #(.WIDTH(32), .SKID(1), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .flush(t_fl), .up_valid(t_uv), .up_ready(t_ur),
    .up_data(t_ud), .dn_valid(t_dv), .dn_ready(t_dr), .dn_data(t_dd),
    .occupancy(t_occ), .stall_cnt(t_st));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for u_skid: arrival order in, departure order out.
  logic [31:0] sb[$];
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb.delete();
    end else begin
      if (s_dv && s_dr) begin
        chk("sb_nonempty_on_pop", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) chk("sb_order", 64'(s_dd), 64'(sb.pop_front()));
      end
      if (s_fl) sb.delete();
      else if (s_uv && s_ur) sb.push_back(s_ud);
    end
  end

  typedef struct {
    logic        uv;
    logic [31:0] ud;
    logic        dr;
    logic        fl;
    logic        dv;
    logic [31:0] dd;
    logic [1:0]  occ;
    logic        ur;
    logic [15:0] st;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    //          uv    ud      dr    fl   | dv    dd      occ   ur    stall
    tbl[0] = '{1'b1, 32'hA, 1'b0, 1'b0, 1'b1, 32'hA, 2'd1, 1'b1, 16'd0};
    tbl[1] = '{1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 32'hA, 2'd2, 1'b0, 16'd1};
    tbl[2] = '{1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 32'hA, 2'd2, 1'b0, 16'd2};
    tbl[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hB, 2'd1, 1'b1, 16'd2};
    tbl[4] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 16'd2};
    tbl[5] = '{1'b1, 32'hA, 1'b0, 1'b0, 1'b1, 32'hA, 2'd1, 1'b1, 16'd2};
    tbl[6] = '{1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 32'hA, 2'd2, 1'b0, 16'd3};
    tbl[7] = '{1'b1, 32'hC, 1'b0, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 16'd4};
    tbl[8] = '{1'b1, 32'hD, 1'b1, 1'b0, 1'b1, 32'hD, 2'd1, 1'b1, 16'd4};
    tbl[9] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 16'd4};

    // Reset state
    reset = 1'b0;
    tick(); tick();
    chk("rst_skid_dv", 64'(s_dv), 64'd0);
    chk("rst_skid_occ", 64'(s_occ), 64'd0);
    chk("rst_skid_ur", 64'(s_ur), 64'd1);
    chk("rst_skid_st", 64'(s_st), 64'd0);
    chk("rst_noskid_dv", 64'(n_dv), 64'd0);
    chk("rst_noskid_ur", 64'(n_ur), 64'd1);
    chk("rst_sat_st", 64'(t_st), 64'd0);
    reset = 1'b1;
    tick();

    // Back-to-back streaming, one word per cycle
    s_dr = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      s_uv = 1'b1; s_ud = 32'(k);
      tick();
      chk("stream_dv", 64'(s_dv), 64'd1);
      chk("stream_dd", 64'(s_dd), 64'(k));
      chk("stream_occ", 64'(s_occ), 64'd1);
    end
    s_uv = 1'b0;
    tick();
    chk("stream_drain_dv", 64'(s_dv), 64'd0);
    chk("stream_st", 64'(s_st), 64'd0);

    // Backpressure and flush vectors
    for (int i = 0; i < 10; i++) begin
      s_uv = tbl[i].uv; s_ud = tbl[i].ud; s_dr = tbl[i].dr; s_fl = tbl[i].fl;
      tick();
      chk($sformatf("vec%0d_dv", i), 64'(s_dv), 64'(tbl[i].dv));
      if (tbl[i].dv) chk($sformatf("vec%0d_dd", i), 64'(s_dd), 64'(tbl[i].dd));
      chk($sformatf("vec%0d_occ", i), 64'(s_occ), 64'(tbl[i].occ));
      chk($sformatf("vec%0d_ur", i), 64'(s_ur), 64'(tbl[i].ur));
      chk($sformatf("vec%0d_st", i), 64'(s_st), 64'(tbl[i].st));
    end
    s_uv = 1'b0; s_fl = 1'b0; s_dr = 1'b0;

    // SKID=0: combinational ready
    n_uv = 1'b1; n_ud = 32'h11; n_dr = 1'b0;
    #1 chk("ns_ur_empty", 64'(n_ur), 64'd1);
    tick();
    chk("ns_load_dd", 64'(n_dd), 64'h11);
    chk("ns_occ", 64'(n_occ), 64'd1);
    n_ud = 32'h22;
    #1 chk("ns_ur_stall", 64'(n_ur), 64'd0);
    tick();
    chk("ns_hold_dd", 64'(n_dd), 64'h11);
    n_dr = 1'b1;
    #1 chk("ns_ur_release", 64'(n_ur), 64'd1);
    tick();
    chk("ns_next_dv", 64'(n_dv), 64'd1);
    chk("ns_next_dd", 64'(n_dd), 64'h22);
    for (int k = 3; k <= 4; k++) begin
      n_ud = 32'(k * 17);
      tick();
      chk("ns_stream_dd", 64'(n_dd), 64'(k * 17));
    end
    n_uv = 1'b0;
    tick();
    chk("ns_drain_dv", 64'(n_dv), 64'd0);
    chk("ns_drain_occ", 64'(n_occ), 64'd0);
    chk("ns_st", 64'(n_st), 64'd1);

    // Stall counter saturation with CNT_W=4
    t_uv = 1'b1; t_ud = 32'h5; t_dr = 1'b0;
    tick();
    t_uv = 1'b0;
    repeat (20) tick();
    chk("sat_15", 64'(t_st), 64'd15);
    tick();
    chk("sat_hold", 64'(t_st), 64'd15);
    t_fl = 1'b1;
    tick();
    t_fl = 1'b0;
    chk("sat_flush_st", 64'(t_st), 64'd15);
    chk("sat_flush_dv", 64'(t_dv), 64'd0);

    // Async reset while FULL
    s_uv = 1'b1; s_ud = 32'hA; s_dr = 1'b0;
    tick();
    s_ud = 32'hB;
    tick();
    s_uv = 1'b0;
    chk("pre_rst_occ", 64'(s_occ), 64'd2);
    #2 reset = 1'b0;
    #1;
    chk("arst_dv", 64'(s_dv), 64'd0);
    chk("arst_dd", 64'(s_dd), 64'd0);
    chk("arst_occ", 64'(s_occ), 64'd0);
    chk("arst_ur", 64'(s_ur), 64'd1);
    chk("arst_st", 64'(s_st), 64'd0);
    chk("arst_sat_st", 64'(t_st), 64'd0);
    tick(); tick();
    chk("arst_hold_dv", 64'(s_dv), 64'd0);
    reset = 1'b1;
    s_uv = 1'b1; s_ud = 32'h55; s_dr = 1'b1;
    tick();
    chk("post_rst_dv", 64'(s_dv), 64'd1);
    chk("post_rst_dd", 64'(s_dd), 64'h55);
    s_uv = 1'b0;
    tick();
    chk("post_rst_drain", 64'(s_dv), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
